// File: rtl/neuron_stream_mac.sv
// Streaming fully connected neuron: sum(pixel*weight) + bias over NUM_INPUTS terms,
// LANES pairs per beat, full-precision accumulation, saturating output, optional ReLU.
`timescale 1ns/1ps

// state  | meaning
// IDLE   | waiting for start; out/out_valid hold the last result
// LOAD   | accepting operand beats (in_ready=1)
// DRAIN  | last product stage flushes into the accumulator
// FINISH | bias add, saturation, ReLU; result registered
// DONE   | done pulse, result valid; returns to IDLE
module neuron_stream_mac #(
  parameter int NUM_INPUTS   = 784,
  parameter int LANES        = 4,
  parameter int PIXEL_WIDTH  = 10,
  parameter int WEIGHT_WIDTH = 19,
  parameter int OUTPUT_WIDTH = 26
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [WEIGHT_WIDTH-1:0]         bias,
  input  logic                            relu_en,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [LANES*PIXEL_WIDTH-1:0]    in_pixels,
  input  logic [LANES*WEIGHT_WIDTH-1:0]   in_weights,
  output logic                            busy,
  output logic                            done,
  output logic                            out_valid,
  output logic [OUTPUT_WIDTH-1:0]         out
);

  localparam int BEATS     = NUM_INPUTS / LANES;
  localparam int CNT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int ACC_WIDTH = PIXEL_WIDTH + WEIGHT_WIDTH + 1 + $clog2(NUM_INPUTS);
  localparam int PROD_W    = PIXEL_WIDTH + 1 + WEIGHT_WIDTH;
  localparam int SUM_W     = ACC_WIDTH + 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [2:0] {IDLE, LOAD, DRAIN, FINISH, DONE} state_t;

  state_t                         state;
  logic [CNT_W-1:0]               beat_cnt;
  logic signed [ACC_WIDTH-1:0]    acc;
  logic signed [ACC_WIDTH-1:0]    p_prod [LANES];
  logic                           p_valid;
  logic signed [WEIGHT_WIDTH-1:0] bias_q;
  logic                           relu_q;

  logic                           accept;
  logic signed [PIXEL_WIDTH:0]    px_s   [LANES];
  logic signed [WEIGHT_WIDTH-1:0] wt_s   [LANES];
  logic signed [PROD_W-1:0]       prod   [LANES];
  logic signed [ACC_WIDTH-1:0]    lane_prod [LANES];
  logic signed [ACC_WIDTH-1:0]    p_sum;
  logic signed [SUM_W-1:0]        total;
  logic [OUTPUT_WIDTH-1:0]        result;

  assign accept = in_valid && in_ready;

  // Pixels are unsigned, so a zero MSB makes them safe signed multiplicands.
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      px_s[k]      = $signed({1'b0, in_pixels[k*PIXEL_WIDTH +: PIXEL_WIDTH]});
      wt_s[k]      = $signed(in_weights[k*WEIGHT_WIDTH +: WEIGHT_WIDTH]);
      prod[k]      = px_s[k] * wt_s[k];
      lane_prod[k] = ACC_WIDTH'(prod[k]);
    end
  end

  always_comb begin
    p_sum = '0;
    for (int k = 0; k < LANES; k++) begin
      p_sum = p_sum + p_prod[k];
    end
  end

  assign total = SUM_W'(acc) + SUM_W'(bias_q);

  always_comb begin
    result = total[OUTPUT_WIDTH-1:0];
    if (total[SUM_W-1:OUTPUT_WIDTH-1] != {(SUM_W-OUTPUT_WIDTH+1){total[SUM_W-1]}}) begin
      result = total[SUM_W-1] ? {1'b1, {(OUTPUT_WIDTH-1){1'b0}}}
                              : {1'b0, {(OUTPUT_WIDTH-1){1'b1}}};
    end
    if (relu_q && total[SUM_W-1]) begin
      result = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      beat_cnt  <= '0;
      acc       <= '0;
      p_valid   <= 1'b0;
      for (int k = 0; k < LANES; k++) p_prod[k] <= '0;
      bias_q    <= '0;
      relu_q    <= 1'b0;
      out       <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b0;
    end else begin
      done <= 1'b0;
      // Bubbles leave p_valid low, so stalled cycles contribute nothing.
      p_valid <= accept;
      if (accept) p_prod <= lane_prod;
      if (p_valid) acc <= acc + p_sum;

      case (state)
        IDLE: begin
          if (start) begin
            bias_q    <= bias;
            relu_q    <= relu_en;
            acc       <= '0;
            beat_cnt  <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b1;
            in_ready  <= 1'b1;
            state     <= LOAD;
          end
        end
        LOAD: begin
          if (accept) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (beat_cnt == LAST_BEAT) begin
              in_ready <= 1'b0;
              state    <= DRAIN;
            end
          end
        end
        DRAIN: state <= FINISH;
        FINISH: begin
          out       <= result;
          out_valid <= 1'b1;
          done      <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_stream_mac.sv
// Bench for neuron_stream_mac: directed and randomized runs on an 8-input instance,
// plus one run of the default 784-input configuration.
`timescale 1ns/1ps

module tb_neuron_stream_mac;
  localparam int NI = 8, LN = 4, PW = 10, WW = 19, OW = 26, NB = NI / LN;
  localparam int DNI = 784;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic            start, relu_en, in_valid, in_ready, busy, done, out_valid;
  logic [WW-1:0]   bias;
  logic [LN*PW-1:0] in_pixels;
  logic [LN*WW-1:0] in_weights;
  logic [OW-1:0]   out;

  logic            d_start, d_relu_en, d_in_valid, d_in_ready, d_busy, d_done, d_out_valid;
  logic [WW-1:0]   d_bias;
  logic [LN*PW-1:0] d_in_pixels;
  logic [LN*WW-1:0] d_in_weights;
  logic [OW-1:0]   d_out;

  neuron_stream_mac #(.NUM_INPUTS(NI), .LANES(LN)) dut (
    .clk(clk), .rst(rst), .start(start), .bias(bias), .relu_en(relu_en),
    .in_valid(in_valid), .in_ready(in_ready), .in_pixels(in_pixels), .in_weights(in_weights),
    .busy(busy), .done(done), .out_valid(out_valid), .out(out));

  neuron_stream_mac dut_default (
    .clk(clk), .rst(rst), .start(d_start), .bias(d_bias), .relu_en(d_relu_en),
    .in_valid(d_in_valid), .in_ready(d_in_ready), .in_pixels(d_in_pixels),
    .in_weights(d_in_weights), .busy(d_busy), .done(d_done), .out_valid(d_out_valid),
    .out(d_out));

  int errors = 0;
  int checks = 0;

  logic [PW-1:0] px [NI];
  logic [WW-1:0] wt [NI];
  logic [OW-1:0] r_out;
  int r_lat, r_beats, r_last;

  // Reference: exact integer dot product, then clamp to the output range, then ReLU.
  function automatic logic [OW-1:0] model(input logic [WW-1:0] b, input bit relu);
    longint s;
    s = longint'($signed(b));
    for (int i = 0; i < NI; i++) s += longint'(px[i]) * longint'($signed(wt[i]));
    if (s > 64'sd33554431) s = 64'sd33554431;
    else if (s < -64'sd33554432) s = -64'sd33554432;
    if (relu && s < 0) s = 0;
    return s[OW-1:0];
  endfunction

  task automatic set_ops(input logic [PW-1:0] p, input logic [WW-1:0] w);
    for (int i = 0; i < NI; i++) begin
      px[i] = p;
      wt[i] = w;
    end
  endtask

  task automatic drive_beat(input int beat);
    for (int l = 0; l < LN; l++) begin
      in_pixels[l*PW +: PW]  = px[beat*LN + l];
      in_weights[l*WW +: WW] = wt[beat*LN + l];
    end
  endtask

  // mode 0: in_valid always 1; mode 1: pattern 1,0,0,1; mode 2: random.
  // After the last beat in_valid stays high with junk so extra acceptance is visible.
  task automatic run_neuron(input logic [WW-1:0] b, input bit relu, input int mode,
                            input bit start_in_load);
    int n, beat, k;
    bit v;
    int pat [4] = '{1, 0, 0, 1};
    @(posedge clk); #1;
    start = 1'b1; bias = b; relu_en = relu; in_valid = 1'b0;
    @(posedge clk); #1;
    start = start_in_load;
    n = 1; beat = 0; k = 0; r_last = 0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL start_state: out_valid=%b busy=%b required out_valid=0 busy=1", out_valid, busy);
    end
    while (done !== 1'b1 && n < 64) begin
      if (n == 3) start = 1'b0;
      if (beat < NB) begin
        v = (mode == 0) ? 1'b1 : (mode == 1) ? (pat[k % 4] == 1) : ($urandom_range(0, 1) == 1);
        k++;
        if (v) drive_beat(beat);
        else begin
          in_pixels  = LN*PW'({$urandom(), $urandom()});
          in_weights = LN*WW'({$urandom(), $urandom(), $urandom()});
        end
      end else begin
        v = 1'b1;
        in_pixels  = LN*PW'({$urandom(), $urandom()});
        in_weights = LN*WW'({$urandom(), $urandom(), $urandom()});
      end
      in_valid = v;
      if (v && in_ready === 1'b1) begin
        if (beat < NB) r_last = n;
        beat++;
      end
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0; in_valid = 1'b0;
    r_lat = n; r_beats = beat; r_out = out;
    if (done !== 1'b1) begin
      checks++; errors++;
      $display("FAIL done_timeout: no done within %0d cycles", n);
    end
  endtask

  task automatic test_reset;
    start = 0; bias = '0; relu_en = 0; in_valid = 0; in_pixels = '0; in_weights = '0;
    d_start = 0; d_bias = '0; d_relu_en = 0; d_in_valid = 0; d_in_pixels = '0; d_in_weights = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({out_valid, done, busy, in_ready} !== 4'b0000 || out !== '0) begin
      errors++;
      $display("FAIL reset_outputs: out=%h flags=%b%b%b%b required 0 and 0000", out, out_valid, done, busy, in_ready);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b in_ready=%b required 0 0", busy, in_ready);
    end
  endtask

  task automatic test_basic;
    set_ops(10'd1, 19'h04000);
    run_neuron(19'h0, 1'b0, 0, 1'b0);
    checks++;
    if (r_out !== 26'h0020000) begin
      errors++; $display("FAIL basic_out: got %h required %h", r_out, 26'h0020000);
    end
    checks++;
    if (r_lat !== 5) begin
      errors++; $display("FAIL basic_latency: got %0d required 5", r_lat);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out !== 26'h0020000 || out_valid !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL output_hold: out=%h out_valid=%b done=%b busy=%b required 0020000 1 0 0", out, out_valid, done, busy);
    end
    run_neuron(19'h10000, 1'b0, 0, 1'b0);
    checks++;
    if (r_out !== 26'h0030000) begin
      errors++; $display("FAIL basic_bias: got %h required %h", r_out, 26'h0030000);
    end
  endtask

  task automatic test_relu;
    set_ops(10'd1, 19'h7C000);
    run_neuron(19'h0, 1'b0, 0, 1'b0);
    checks++;
    if (r_out !== 26'h3FE0000) begin
      errors++; $display("FAIL negative_out: got %h required %h", r_out, 26'h3FE0000);
    end
    run_neuron(19'h0, 1'b1, 0, 1'b0);
    checks++;
    if (r_out !== 26'h0) begin
      errors++; $display("FAIL relu_out: got %h required 0", r_out);
    end
  endtask

  task automatic test_saturation;
    set_ops(10'd1023, 19'h3FFFF);
    run_neuron(19'h0, 1'b0, 0, 1'b0);
    checks++;
    if (r_out !== 26'h1FFFFFF) begin
      errors++; $display("FAIL sat_pos: got %h required %h", r_out, 26'h1FFFFFF);
    end
    set_ops(10'd1023, 19'h40000);
    run_neuron(19'h0, 1'b0, 0, 1'b0);
    checks++;
    if (r_out !== 26'h2000000) begin
      errors++; $display("FAIL sat_neg: got %h required %h", r_out, 26'h2000000);
    end
  endtask

  task automatic test_stall;
    set_ops(10'd1, 19'h04000);
    run_neuron(19'h0, 1'b0, 1, 1'b0);
    checks++;
    if (r_out !== 26'h0020000) begin
      errors++; $display("FAIL stall_out: got %h required %h", r_out, 26'h0020000);
    end
    checks++;
    if (r_lat !== 7) begin
      errors++; $display("FAIL stall_latency: got %0d required 7", r_lat);
    end
    checks++;
    if (r_beats !== NB) begin
      errors++; $display("FAIL stall_beats: consumed %0d required %0d", r_beats, NB);
    end
  endtask

  task automatic test_reset_mid;
    bit seen;
    set_ops(10'd1, 19'h04000);
    @(posedge clk); #1;
    start = 1'b1; bias = '0; relu_en = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b1; drive_beat(0);
    @(posedge clk); #1;
    in_valid = 1'b0; rst = 1'b1;
    #1;
    checks++;
    if (out !== '0 || {out_valid, done, busy, in_ready} !== 4'b0000) begin
      errors++;
      $display("FAIL midrun_reset: out=%h flags=%b%b%b%b required 0 and 0000", out, out_valid, done, busy, in_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++; $display("FAIL midrun_no_done: done=1 seen required none");
    end
    run_neuron(19'h0, 1'b0, 0, 1'b0);
    checks++;
    if (r_out !== 26'h0020000) begin
      errors++; $display("FAIL after_reset_out: got %h required %h", r_out, 26'h0020000);
    end
  endtask

  task automatic test_ignored_start;
    set_ops(10'd1, 19'h04000);
    run_neuron(19'h0, 1'b0, 0, 1'b1);
    checks++;
    if (r_out !== 26'h0020000 || r_lat !== 5) begin
      errors++;
      $display("FAIL ignored_start: out=%h lat=%0d required 0020000 lat=5", r_out, r_lat);
    end
  endtask

  task automatic test_random;
    logic [WW-1:0] b;
    bit relu;
    logic [OW-1:0] exp_out;
    for (int it = 0; it < 8; it++) begin
      for (int i = 0; i < NI; i++) begin
        px[i] = PW'($urandom());
        wt[i] = (it % 2 == 0) ? WW'($urandom()) : WW'($signed(12'($urandom())));
      end
      b = WW'($urandom());
      relu = ($urandom_range(0, 1) == 1);
      exp_out = model(b, relu);
      run_neuron(b, relu, 2, 1'b0);
      checks++;
      if (r_out !== exp_out) begin
        errors++; $display("FAIL random_out[%0d]: got %h required %h", it, r_out, exp_out);
      end
      checks++;
      if (r_lat !== r_last + 3 || r_beats !== NB) begin
        errors++;
        $display("FAIL random_timing[%0d]: done at %0d last beat %0d beats %0d required last+3 and %0d beats",
                 it, r_lat, r_last, r_beats, NB);
      end
    end
  endtask

  task automatic test_back_to_back;
    int n, beat;
    logic [OW-1:0] exp_out;
    set_ops(10'd1, 19'h04000);
    run_neuron(19'h0, 1'b0, 0, 1'b0);
    start = 1'b1; bias = '0; relu_en = 1'b0;
    for (int i = 0; i < NI; i++) begin
      px[i] = PW'($urandom());
      wt[i] = WW'($signed(12'($urandom())));
    end
    exp_out = model(19'h0, 1'b0);
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle: busy=%b in_ready=%b done=%b required 0 0 0", busy, in_ready, done);
    end
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_load: busy=%b in_ready=%b required 1 1", busy, in_ready);
    end
    n = 2; beat = 0;
    while (done !== 1'b1 && n < 40) begin
      if (beat < NB) begin
        drive_beat(beat);
        in_valid = 1'b1;
        if (in_ready === 1'b1) beat++;
      end else in_valid = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    checks++;
    if (n !== NB + 4 || out !== exp_out) begin
      errors++;
      $display("FAIL b2b_result: period=%0d out=%h required period=%0d out=%h", n, out, NB + 4, exp_out);
    end
  endtask

  task automatic test_default;
    int n;
    for (int l = 0; l < LN; l++) begin
      d_in_pixels[l*PW +: PW]  = 10'd1;
      d_in_weights[l*WW +: WW] = 19'h00100;
    end
    @(posedge clk); #1;
    d_start = 1'b1; d_bias = '0; d_relu_en = 1'b0;
    @(posedge clk); #1;
    d_start = 1'b0; d_in_valid = 1'b1;
    n = 1;
    while (d_done !== 1'b1 && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    d_in_valid = 1'b0;
    checks++;
    if (d_out !== 26'h0031000) begin
      errors++; $display("FAIL default_out: got %h required %h", d_out, 26'h0031000);
    end
    checks++;
    if (n !== DNI / LN + 3) begin
      errors++; $display("FAIL default_latency: got %0d required %0d", n, DNI / LN + 3);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_relu();
    test_saturation();
    test_stall();
    test_reset_mid();
    test_ignored_start();
    test_random();
    test_back_to_back();
    test_default();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
